// File: rtl/seg7_pkg.sv
// seg7_pkg: shared segment/anode codes for the seven-segment scan driver
// Segment codes are active-low {g,f,e,d,c,b,a}; anode codes are active-low.
package seg7_pkg;
  localparam int NUM_DIGITS = 6;
  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [5:0] AN_OFF   = 6'h3F;
endpackage

// File: rtl/bcd_to_seg7.sv
// bcd_to_seg7: combinational BCD to active-low seven-segment decoder
// Ports: i_bcd - 4-bit code; o_seg - {g,f,e,d,c,b,a} active-low, A-F shown as a dash.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);
  always_comb begin
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_DASH;
    endcase
  end
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexes six snapshotted BCD digits onto a common-anode display
// Ports: i_clk/i_rst (async, active-high); i_en display enable; i_lzb leading-zero blanking;
// i_colon_en colon dots; i_hr_h..i_sec_l BCD digits; o_an_n anodes (bit0 = sec_l),
// o_seg_n segments {g,f,e,d,c,b,a}, o_dp_n decimal point, all active-low and registered.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 100000,
  parameter int unsigned BLANK_CYC = 1000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic       i_lzb,
  input  logic       i_colon_en,
  input  logic [3:0] i_hr_h,
  input  logic [3:0] i_hr_l,
  input  logic [3:0] i_min_h,
  input  logic [3:0] i_min_l,
  input  logic [3:0] i_sec_h,
  input  logic [3:0] i_sec_l,
  output logic [5:0] o_an_n,
  output logic [6:0] o_seg_n,
  output logic       o_dp_n
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DIV_MAX = DW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] BLANK = DW'(BLANK_CYC);
  localparam logic [2:0] LAST = 3'(NUM_DIGITS - 1);
  logic [DW-1:0] r_div_cnt;
  logic [2:0]    r_idx;
  logic [23:0]   r_snap;
  logic          w_wrap;
  logic          w_lzb_blank;
  logic          w_lit;
  logic [3:0]    w_digit;
  logic [6:0]    w_seg;
  assign w_wrap = r_div_cnt == DIV_MAX;
  // snapshot packs sec_l in the low nibble so idx selects nibble idx
  assign w_digit = 4'(r_snap >> {r_idx, 2'b00});
  assign w_lzb_blank = i_lzb && r_snap[23:20] == 4'd0 &&
                       (r_idx == 3'd5 || (r_idx == 3'd4 && r_snap[19:16] == 4'd0));
  assign w_lit = i_en && r_div_cnt >= BLANK && !w_lzb_blank;
  bcd_to_seg7 u_dec (
    .i_bcd(w_digit),
    .o_seg(w_seg)
  );
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_div_cnt <= '0;
      r_idx     <= 3'd0;
      r_snap    <= '0;
      o_an_n    <= AN_OFF;
      o_seg_n   <= SEG_OFF;
      o_dp_n    <= 1'b1;
    end else begin
      r_div_cnt <= w_wrap ? '0 : r_div_cnt + 1'b1;
      r_idx     <= (r_idx > LAST) ? 3'd0 : !w_wrap ? r_idx : (r_idx == LAST) ? 3'd0 : r_idx + 3'd1;
      // capture on the edge that returns to slot 0 so a whole frame shows one coherent time
      if (w_wrap && r_idx == LAST)
        r_snap <= {i_hr_h, i_hr_l, i_min_h, i_min_l, i_sec_h, i_sec_l};
      o_an_n    <= w_lit ? ~(6'b1 << r_idx) : AN_OFF;
      o_seg_n   <= w_lit ? w_seg : SEG_OFF;
      o_dp_n    <= !(w_lit && i_colon_en && (r_idx == 3'd2 || r_idx == 3'd4));
    end
  end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed bench with a cycle-position display model for seg7_scan_driver
module tb_seg7_scan_driver;
  localparam int SD = 8;
  localparam int BC = 2;
  localparam int FRAME = 6 * SD;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b0, lzb = 1'b0, colon_en = 1'b0;
  logic [3:0] hr_h = 0, hr_l = 0, min_h = 0, min_l = 0, sec_h = 0, sec_l = 0;
  logic [5:0] an_n;
  logic [6:0] seg_n;
  logic dp_n;
  int checks = 0;
  int errors = 0;
  int pos = 0;
  int snap [6];
  logic [6:0] segt [16];
  logic [5:0] e_an;
  logic [6:0] e_seg;
  logic e_dp;
  logic active = 1'b0;

  seg7_scan_driver #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_lzb(lzb), .i_colon_en(colon_en),
    .i_hr_h(hr_h), .i_hr_l(hr_l), .i_min_h(min_h), .i_min_l(min_l),
    .i_sec_h(sec_h), .i_sec_l(sec_l),
    .o_an_n(an_n), .o_seg_n(seg_n), .o_dp_n(dp_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
    end
  endtask

  task automatic lit_chk(input string nm, input logic [5:0] an, input logic [6:0] seg, input logic dp);
    chk({nm, "_an"}, {1'b0, an_n}, {1'b0, an});
    chk({nm, "_seg"}, seg_n, seg);
    chk({nm, "_dp"}, {6'd0, dp_n}, {6'd0, dp});
  endtask

  // return just after the edge whose outputs reflect scan position p
  task automatic at_out(input int p);
    int n = 0;
    while (pos != p + 1 && n < 1000) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (pos != p + 1) begin
      errors++;
      $display("FAIL wait_pos: got %0d want %0d", pos, p + 1);
    end
  endtask

  // model: the position p=edges since reset gives slot p/SD mod 6 and offset p mod SD;
  // outputs after an edge describe the position before it, digits come from the frame snapshot
  always @(posedge clk) begin
    if (rst) begin
      pos = 0;
      for (int i = 0; i < 6; i++) snap[i] = 0;
      e_an = 6'h3F; e_seg = 7'h7F; e_dp = 1'b1;
      active = 1'b1;
    end else if (active) begin
      int off, slot, d;
      bit lit, blanked;
      off = pos % SD;
      slot = (pos / SD) % 6;
      d = snap[slot];
      blanked = lzb && ((slot == 5 && snap[5] == 0) || (slot == 4 && snap[5] == 0 && snap[4] == 0));
      lit = en && off >= BC && !blanked;
      e_an = lit ? 6'h3F & ~(6'(1) << slot) : 6'h3F;
      e_seg = lit ? segt[d] : 7'h7F;
      e_dp = !(lit && colon_en && (slot == 2 || slot == 4));
      if (pos % FRAME == FRAME - 1) begin
        snap[0] = sec_l; snap[1] = sec_h; snap[2] = min_l;
        snap[3] = min_h; snap[4] = hr_l; snap[5] = hr_h;
      end
      pos++;
    end
    #1;
    if (active) begin
      chk("model_an", {1'b0, an_n}, {1'b0, e_an});
      chk("model_seg", seg_n, e_seg);
      chk("model_dp", {6'd0, dp_n}, {6'd0, e_dp});
    end
  end

  initial begin
    segt = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
             7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
    #1 rst = 1'b1;
    repeat (5) @(posedge clk);
    #1 lit_chk("in_reset", 6'h3F, 7'h7F, 1'b1);
    @(negedge clk);
    rst = 1'b0; en = 1'b1; lzb = 1'b0;
    at_out(1); lit_chk("rel_dark", 6'h3F, 7'h7F, 1'b1);
    at_out(2); lit_chk("rel_lit0", 6'h3E, 7'h40, 1'b1);
    at_out(7); lit_chk("rel_lit5", 6'h3E, 7'h40, 1'b1);
    at_out(8); lit_chk("rel_slot1_dark", 6'h3F, 7'h7F, 1'b1);
    @(negedge clk);
    hr_h = 1; hr_l = 2; min_h = 3; min_l = 4; sec_h = 5; sec_l = 6;
    at_out(FRAME + 3);      lit_chk("f1_s0", 6'h3E, 7'h02, 1'b1);
    at_out(FRAME + 11);     lit_chk("f1_s1", 6'h3D, 7'h12, 1'b1);
    at_out(FRAME + 19);     lit_chk("f1_s2", 6'h3B, 7'h19, 1'b1);
    @(negedge clk) sec_l = 7;
    at_out(FRAME + 27);     lit_chk("f1_s3", 6'h37, 7'h30, 1'b1);
    at_out(FRAME + 35);     lit_chk("f1_s4", 6'h2F, 7'h24, 1'b1);
    at_out(FRAME + 43);     lit_chk("f1_s5", 6'h1F, 7'h79, 1'b1);
    at_out(2 * FRAME + 3);  lit_chk("f2_s0_new", 6'h3E, 7'h78, 1'b1);
    @(negedge clk);
    sec_l = 4'hB; colon_en = 1'b1;
    at_out(3 * FRAME + 3);  lit_chk("f3_dash", 6'h3E, 7'h3F, 1'b1);
    at_out(3 * FRAME + 17); lit_chk("f3_s2_dark", 6'h3F, 7'h7F, 1'b1);
    at_out(3 * FRAME + 19); lit_chk("f3_colon2", 6'h3B, 7'h19, 1'b0);
    at_out(3 * FRAME + 27); lit_chk("f3_s3_nodp", 6'h37, 7'h30, 1'b1);
    at_out(3 * FRAME + 37); lit_chk("f3_colon4", 6'h2F, 7'h24, 1'b0);
    @(negedge clk);
    hr_h = 0; hr_l = 0; lzb = 1'b1;
    at_out(4 * FRAME + 35); lit_chk("f4_hrl_blank", 6'h3F, 7'h7F, 1'b1);
    at_out(4 * FRAME + 43); lit_chk("f4_hrh_blank", 6'h3F, 7'h7F, 1'b1);
    @(negedge clk) hr_l = 5;
    at_out(5 * FRAME + 35); lit_chk("f5_hrl_5", 6'h2F, 7'h12, 1'b0);
    at_out(5 * FRAME + 43); lit_chk("f5_hrh_blank", 6'h3F, 7'h7F, 1'b1);
    at_out(6 * FRAME + 1);
    @(negedge clk) en = 1'b0;
    at_out(6 * FRAME + 7);  lit_chk("en_off", 6'h3F, 7'h7F, 1'b1);
    repeat (10) @(negedge clk);
    en = 1'b1;
    at_out(6 * FRAME + 18); lit_chk("en_resume", 6'h3B, 7'h19, 1'b0);
    at_out(6 * FRAME + 28);
    @(negedge clk) rst = 1'b1;
    #1 lit_chk("async_rst", 6'h3F, 7'h7F, 1'b1);
    @(negedge clk) rst = 1'b0;
    at_out(1);  lit_chk("rst2_dark", 6'h3F, 7'h7F, 1'b1);
    at_out(2);  lit_chk("rst2_lit0", 6'h3E, 7'h40, 1'b1);
    at_out(FRAME + 3); lit_chk("rst2_f1_s0", 6'h3E, 7'h3F, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
